// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them onto
// UART_TXD as start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx_serializer #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       TX_EN,
    input  logic       FIFO_Empty,
    input  logic [7:0] FIFO_RD_DATA,
    output logic       FIFO_RDEN,
    output logic       UART_TXD,
    output logic       TX_BUSY,
    output logic       TX_DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 32'd1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 32'd1);
    localparam logic        PAR_EN    = (PARITY_EN != 32'd0);
    localparam logic        PAR_ODD   = (PARITY_ODD != 32'd0);

    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        rden_q, rden_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end_s;

    // Next-state, baud counter, bit index and shift register update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_end_s = (cnt_q == BIT_LAST);
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (TX_EN && !FIFO_Empty) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = FIFO_RD_DATA;
                par_d   = frame_parity(FIFO_RD_DATA, PAR_ODD);
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = START;
            end
            START: begin
                if (bit_end_s) begin
                    cnt_d   = 16'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    // index wraps 7 -> 0, so it is ready to count stop bits
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = 16'd0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    cnt_d = 16'd0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so the flops line up with the state they describe.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
        rden_d = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (idx_d == STOP_LAST) && (cnt_d == BIT_LAST);
    end

    // State and output registers.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            rden_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            rden_q  <= rden_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign FIFO_RDEN = rden_q;
    assign UART_TXD  = txd_q;
    assign TX_BUSY   = busy_q;
    assign TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations driven from small FIFO
// models, every cycle compared against a frame-level reference model.
module tb_uart_tx_serializer;

    localparam int NI = 3;
    localparam int CFG_DIV [NI] = '{4, 4, 2};
    localparam int CFG_PE  [NI] = '{0, 1, 1};
    localparam int CFG_PO  [NI] = '{0, 0, 1};
    localparam int CFG_SB  [NI] = '{1, 2, 1};

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tx_en = 1'b1;
    logic       empty [NI];
    logic [7:0] rdata [NI] = '{8'h00, 8'h00, 8'h00};
    logic       rden  [NI];
    logic       txd   [NI];
    logic       busy  [NI];
    logic       done  [NI];

    logic [7:0] fmem  [NI][64];
    int         fwr   [NI] = '{0, 0, 0};
    int         frd   [NI] = '{0, 0, 0};
    int         mrd   [NI] = '{0, 0, 0};
    int         fpos  [NI] = '{-1, -1, -1};
    logic [7:0] fbyte [NI] = '{8'h00, 8'h00, 8'h00};
    logic       go    [NI] = '{1'b0, 1'b0, 1'b0};

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] got_v;
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .SCLK(clk), .RST(rst), .TX_EN(tx_en), .FIFO_Empty(empty[0]), .FIFO_RD_DATA(rdata[0]),
        .FIFO_RDEN(rden[0]), .UART_TXD(txd[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]));
    uart_tx_serializer #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .SCLK(clk), .RST(rst), .TX_EN(tx_en), .FIFO_Empty(empty[1]), .FIFO_RD_DATA(rdata[1]),
        .FIFO_RDEN(rden[1]), .UART_TXD(txd[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]));
    uart_tx_serializer #(.CLK_DIV(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .SCLK(clk), .RST(rst), .TX_EN(tx_en), .FIFO_Empty(empty[2]), .FIFO_RD_DATA(rdata[2]),
        .FIFO_RDEN(rden[2]), .UART_TXD(txd[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2]));

    // FIFO behaviour: data appears the cycle after the pop is sampled.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rden[i]) begin
                rdata[i] <= fmem[i][frd[i][5:0]];
                frd[i]   <= frd[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            empty[i] = (fwr[i] == frd[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][fwr[i][5:0]] = b;
        fwr[i] = fwr[i] + 1;
    endtask

    // Position of the TX_DONE cycle, counting FETCH as position 0.
    function automatic int frame_last(input int i);
        return 1 + (10 + CFG_PE[i] + CFG_SB[i] - 1) * CFG_DIV[i];
    endfunction

    // Expected {txd, busy, done, rden} at position p of a frame carrying byte b.
    function automatic logic [3:0] frame_exp(input int i, input int p, input logic [7:0] b);
        int   slot;
        logic lvl;
        if (p == 0) return 4'b1101;
        if (p == 1) return 4'b1100;
        slot = (p - 2) / CFG_DIV[i];
        if (slot == 0) lvl = 1'b0;
        else if (slot <= 8) lvl = b[slot - 1];
        else if (slot == 9 && CFG_PE[i] == 1) lvl = (^b) ^ (CFG_PO[i] != 0);
        else lvl = 1'b1;
        return {lvl, 1'b1, (p == frame_last(i)), 1'b0};
    endfunction

    // Reference model: predicts every cycle from pushed bytes and frame arithmetic.
    initial begin : model
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    fpos[i] = -1;
                    go[i]   = 1'b0;
                    exp_v   = 4'b1000;
                end else begin
                    if (fpos[i] < 0 && go[i]) begin
                        fpos[i]  = 0;
                        fbyte[i] = fmem[i][mrd[i][5:0]];
                        mrd[i]   = mrd[i] + 1;
                    end
                    exp_v = (fpos[i] < 0) ? 4'b1000 : frame_exp(i, fpos[i], fbyte[i]);
                end
                got_v = {txd[i], busy[i], done[i], rden[i]};
                check_eq($sformatf("u%0d_pins_t%0t", i, $time), 32'(got_v), 32'(exp_v));
                if (!rst) begin
                    if (fpos[i] >= 0) begin
                        go[i]   = 1'b0;
                        fpos[i] = (fpos[i] == frame_last(i)) ? -1 : fpos[i] + 1;
                    end else begin
                        go[i] = tx_en && !empty[i];
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int   n;
        logic idle_all;
        n = 0;
        idle_all = 1'b0;
        while (!idle_all && n < 5000) begin
            @(posedge clk);
            n++;
            idle_all = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (fwr[i] != frd[i] || fpos[i] >= 0 || go[i]) idle_all = 1'b0;
            end
        end
        check_eq("drain_done", 32'(idle_all), 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input int i, input int p);
        int   n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 1000) begin
            @(posedge clk);
            n++;
            if (fpos[i] == p) hit = 1'b1;
        end
        check_eq("reach_pos", 32'(hit), 32'd1);
    endtask

    initial begin
        // Reset held with data waiting and TX_EN high.
        for (int i = 0; i < NI; i++) push(i, 8'hA5);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq("rst_txd", 32'(txd[i]), 32'd1);
            check_eq("rst_busy", 32'(busy[i]), 32'd0);
            check_eq("rst_rden", 32'(rden[i]), 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_drain();

        // Back-to-back frames 0x00 then 0xFF.
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h00);
            push(i, 8'hFF);
        end
        wait_drain();

        // TX_EN dropped mid-DATA with two bytes queued.
        for (int i = 0; i < NI; i++) begin
            push(i, 8'($urandom));
            push(i, 8'($urandom));
        end
        wait_pos(0, 10);
        #2;
        tx_en = 1'b0;
        repeat (120) @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq("en_low_pending", 32'(fwr[i] - frd[i]), 32'd1);
        end
        #2;
        tx_en = 1'b1;
        wait_drain();

        // Asynchronous reset during data bit 3 of u0.
        push(0, 8'($urandom));
        push(0, 8'($urandom));
        wait_pos(0, 19);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_txd", 32'(txd[0]), 32'd1);
        check_eq("async_rst_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_drain();
        check_eq("rst_lost_byte", 32'(frd[0] - mrd[0]), 32'd0);

        // Random traffic with TX_EN toggling.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #2;
            tx_en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 15) == 0 && (fwr[i] - frd[i]) < 48) push(i, 8'($urandom));
            end
        end
        tx_en = 1'b1;
        wait_drain();
        for (int i = 0; i < NI; i++) begin
            check_eq("all_popped", 32'(frd[i]), 32'(fwr[i]));
            check_eq("model_pops", 32'(mrd[i]), 32'(frd[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
